// File: rtl/faculty_fighter_pkg.sv
// Shared keycode map, action indices and decode helper for the fighter game input path.
package faculty_fighter_pkg;

    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_RIGHT = 8'h4F;
    localparam logic [7:0] KC_UP    = 8'h52;
    localparam logic [7:0] KC_DOWN  = 8'h51;

    localparam int NUM_PLAYERS        = 2;
    localparam int ACTIONS_PER_PLAYER = 4;

    typedef enum logic [1:0] {
        ACT_LEFT,
        ACT_RIGHT,
        ACT_JUMP,
        ACT_ATTACK
    } action_e;

    // Bit index is player * ACTIONS_PER_PLAYER + action; at most one bit is ever set.
    function automatic logic [7:0] decode_keycode(input logic [7:0] kc);
        logic [7:0] act;
        act = '0;
        case (kc)
            KC_A:     act[int'(ACT_LEFT)]                         = 1'b1;
            KC_D:     act[int'(ACT_RIGHT)]                        = 1'b1;
            KC_W:     act[int'(ACT_JUMP)]                         = 1'b1;
            KC_S:     act[int'(ACT_ATTACK)]                       = 1'b1;
            KC_LEFT:  act[ACTIONS_PER_PLAYER + int'(ACT_LEFT)]    = 1'b1;
            KC_RIGHT: act[ACTIONS_PER_PLAYER + int'(ACT_RIGHT)]   = 1'b1;
            KC_UP:    act[ACTIONS_PER_PLAYER + int'(ACT_JUMP)]    = 1'b1;
            KC_DOWN:  act[ACTIONS_PER_PLAYER + int'(ACT_ATTACK)]  = 1'b1;
            default:  act = '0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/keycode_action_decoder_if.sv
// Keycode input bundle and per-player action outputs between NIOS export and game logic.
interface keycode_action_decoder_if;
    logic [7:0] keycode;
    logic       frame_tick;
    logic       game_active;
    logic       p1_left, p1_right, p1_jump, p1_attack;
    logic       p2_left, p2_right, p2_jump, p2_attack;
    logic       p1_cd_busy, p2_cd_busy;

    modport master (
        output keycode, frame_tick, game_active,
        input  p1_left, p1_right, p1_jump, p1_attack,
        input  p2_left, p2_right, p2_jump, p2_attack,
        input  p1_cd_busy, p2_cd_busy
    );

    modport slave (
        input  keycode, frame_tick, game_active,
        output p1_left, p1_right, p1_jump, p1_attack,
        output p2_left, p2_right, p2_jump, p2_attack,
        output p1_cd_busy, p2_cd_busy
    );
endinterface

// File: rtl/action_cooldown.sv
// Frame-sampled edge detect with a per-action cooldown; emits a one-cycle fire pulse.
module action_cooldown #(
    parameter int unsigned COOLDOWN = 0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_tick,
    input  logic enable,
    input  logic level,
    output logic fire,
    output logic busy
);
    localparam logic [7:0] CNT_LOAD = 8'(COOLDOWN);

    logic       prev_q, prev_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fire_q, fire_d;
    logic       busy_q, busy_d;

    // prev tracks every frame even when disabled, so a key held across enable never fires.
    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        fire_d = 1'b0;
        if (frame_tick) begin
            prev_d = level;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 8'd1;
            end else if (level && !prev_q && enable) begin
                fire_d = 1'b1;
                cnt_d  = CNT_LOAD;
            end
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
            fire_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            fire_q <= fire_d;
            busy_q <= busy_d;
        end
    end

    assign fire = fire_q;
    assign busy = busy_q;
endmodule

// File: rtl/keycode_action_decoder.sv
// Turns the NIOS HID keycode into frame-synchronous movement levels and cooled-down action pulses.
module keycode_action_decoder
    import faculty_fighter_pkg::*;
#(
    parameter int unsigned JUMP_COOLDOWN   = 30,
    parameter int unsigned ATTACK_COOLDOWN = 15
) (
    input  logic                      Clk,
    input  logic                      Reset,
    keycode_action_decoder_if.slave   bus
);
    logic [7:0] kc_q, kc_d;
    logic [7:0] act;
    logic [NUM_PLAYERS-1:0] left_q, left_d, right_q, right_d;
    logic [NUM_PLAYERS-1:0] jump_fire, jump_busy, attack_fire, attack_busy;

    assign act = decode_keycode(kc_q);

    always_comb begin
        kc_d    = bus.keycode;
        left_d  = left_q;
        right_d = right_q;
        if (bus.frame_tick) begin
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                left_d[p]  = act[p*ACTIONS_PER_PLAYER + int'(ACT_LEFT)]  & bus.game_active;
                right_d[p] = act[p*ACTIONS_PER_PLAYER + int'(ACT_RIGHT)] & bus.game_active;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            kc_q    <= '0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            kc_q    <= kc_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : gen_player
        action_cooldown #(.COOLDOWN(JUMP_COOLDOWN)) u_jump (
            .Clk        (Clk),
            .Reset      (Reset),
            .frame_tick (bus.frame_tick),
            .enable     (bus.game_active),
            .level      (act[p*ACTIONS_PER_PLAYER + int'(ACT_JUMP)]),
            .fire       (jump_fire[p]),
            .busy       (jump_busy[p])
        );
        action_cooldown #(.COOLDOWN(ATTACK_COOLDOWN)) u_attack (
            .Clk        (Clk),
            .Reset      (Reset),
            .frame_tick (bus.frame_tick),
            .enable     (bus.game_active),
            .level      (act[p*ACTIONS_PER_PLAYER + int'(ACT_ATTACK)]),
            .fire       (attack_fire[p]),
            .busy       (attack_busy[p])
        );
    end

    assign bus.p1_left    = left_q[0];
    assign bus.p1_right   = right_q[0];
    assign bus.p1_jump    = jump_fire[0];
    assign bus.p1_attack  = attack_fire[0];
    assign bus.p2_left    = left_q[1];
    assign bus.p2_right   = right_q[1];
    assign bus.p2_jump    = jump_fire[1];
    assign bus.p2_attack  = attack_fire[1];
    assign bus.p1_cd_busy = jump_busy[0] | attack_busy[0];
    assign bus.p2_cd_busy = jump_busy[1] | attack_busy[1];
endmodule

// File: doc/keycode_action_decoder.md
Name: keycode_action_decoder

Overview:
Consumes the 8-bit USB HID keycode exported by the NIOS II keycode PIO and converts it into per-player game actions. Outputs are frame-synchronous: held movement levels plus one-cycle jump and attack pulses, with per-action cooldowns. It sits between the NIOS keycode export and the player motion/combat logic. All logic is in the Clk domain.

Parameters:
JUMP_COOLDOWN, 30, frames during which a new jump edge is ignored after a jump fires (0..255)
ATTACK_COOLDOWN, 15, frames during which a new attack edge is ignored after an attack fires (0..255)

Ports:
Clk  input  1  system clock (50 MHz)
Reset  input  1  synchronous, active-high reset
keycode  input  8  USB HID keycode from NIOS PIO; 0x00 = no key
frame_tick  input  1  one-cycle pulse per video frame (from VGA vsync logic)
game_active  input  1  high = actions enabled
p1_left, p1_right  output  1 each  held movement levels, player 1
p1_jump, p1_attack  output  1 each  one-cycle action pulses, player 1
p2_left, p2_right  output  1 each  held movement levels, player 2
p2_jump, p2_attack  output  1 each  one-cycle action pulses, player 2
p1_cd_busy, p2_cd_busy  output  1 each  high while either cooldown counter of that player is nonzero

Behaviour:
- Key map, fixed: P1 A=0x04 left, D=0x07 right, W=0x1A jump, S=0x16 attack. P2 0x50 left, 0x4F right, 0x52 jump, 0x51 attack. Any other value = no action for both players. At most one action is active at a time.
- keycode is registered once (kc_q). Decoding is combinational from kc_q. Input-to-decode latency is 1 cycle.
- Frame sampling: on a cycle T with frame_tick=1, cur[8] = decode(kc_q) is captured. Outputs change only at T+1. Between ticks, keycode changes are invisible.
- Movement: pX_left/right = sampled level AND game_active_at_T. They hold until the next frame_tick.
- Edge detect: prev[8] holds the previous frame's samples and updates on every frame_tick regardless of game_active. A press is cur=1 and prev=0.
- Fire rule per action at tick T: fire = press AND cnt==0 AND game_active. When firing, the pulse is high only in cycle T+1, and cnt loads the action's COOLDOWN value.
- Non-firing cases at tick T: if cnt!=0, cnt decrements and any press is dropped, not queued. A key held continuously never refires; it must be released and pressed again.
- Cooldown timing: after a fire at frame F, frames F+1..F+COOLDOWN are blocked and F+COOLDOWN+1 is the first eligible frame. COOLDOWN=0 means no blocking.
- Counter width is 8 bits unsigned, with no wrap: decrement only when nonzero.
- game_active low: all movement levels and pulses are 0. Cooldown counters keep decrementing and prev keeps updating, so a key held when game_active rises does not fire.
- frame_tick held high across consecutive cycles: each high cycle counts as a tick (the source guarantees 1-cycle pulses).
- Reset is synchronous, active-high, and takes priority over frame_tick. Reset values: kc_q, cur, prev, counters and all outputs = 0, so every output is 0 in the cycle after Reset is sampled. A key held through reset is seen as a new press at the first tick after reset.
- Cooldown busy: pX_cd_busy is registered and reflects counters after each update (same cycle as the pulses).

Decomposition:
- Package faculty_fighter_pkg: keycode localparams (KC_A, KC_D, KC_W, KC_S, KC_LEFT, KC_RIGHT, KC_UP, KC_DOWN), action index enum (ACT_LEFT, ACT_RIGHT, ACT_JUMP, ACT_ATTACK), player count.
- Sub-module action_cooldown (parameter COOLDOWN; ports Clk, Reset, frame_tick, enable, level, fire, busy), holding the edge detect and counter. Instantiated 4 times (jump/attack × 2 players).

Test Plan:
1. Reset=1 for 3 cycles with keycode=0x1A, then release reset with key held; tick -> all outputs 0 during reset; p1_jump=1 exactly one cycle after the first tick; p1_cd_busy=1.
2. keycode=0x07 held for 5 ticks -> p1_right=1 from tick1+1 through tick5 window; p1_jump/p1_attack stay 0; p2_* stay 0.
3. JUMP_COOLDOWN=3: press W at tick 0, release at tick 1, re-press at tick 2 -> second press dropped. Re-press at tick 4 after release at tick 3 -> p1_jump fires at tick 4+1.
4. keycode changes 0x16->0x00->0x16 between two frame_ticks -> no attack pulse (intra-frame glitch invisible); single pulse at the next tick where sampled 0x16 follows a sampled non-0x16.
5. game_active=0, keycode=0x52 pressed at tick 0 and held; game_active=1 at tick 2 -> p2_jump never fires while held; release then re-press -> fires.
6. keycode=0x2C (unmapped), then 0x51 -> no outputs for 0x2C; p2_attack pulse 1 cycle after the next tick; the P1 outputs are unaffected.
